// File: rtl/fetch_ctrl.sv
// Fetch controller for the RV32 core. It owns the architectural PC and keeps
// at most one instruction fetch outstanding. The returned instruction is held
// until decode takes it. Jump and trap redirects discard any fetch they make
// stale.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    input  logic [31:0] trap_vector,
    output logic [31:0] pc,
    output logic [31:0] snpc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DROP  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;

    logic              redirect;
    logic [XLEN-1:0]   redirect_addr;
    logic              handshake;
    logic [XLEN-1:0]   snpc_c;

    // The low target bits are forced to zero by alignment and are never read.
    logic              unused_align_bits;
    assign unused_align_bits = ^{jump_target[0], trap_vector[1:0]};

    // Trap takes priority over jump. Targets are aligned to 2 and 4 bytes.
    assign redirect      = trap | jump;
    assign redirect_addr = trap ? {trap_vector[XLEN-1:2], 2'b00}
                                : {jump_target[XLEN-1:1], 1'b0};
    assign handshake     = imem_req_valid & imem_req_ready;
    assign snpc_c        = pc_q + XLEN'(4);

    // The request is a decode of the state register. The address is always the PC.
    assign imem_req_valid = (state_q == S_FETCH);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_q;
    assign snpc           = snpc_c;

    // State, PC and instruction buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state logic. A redirect updates the PC and kills the buffered instruction.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect) begin
                    pc_d = redirect_addr;
                end
            end

            S_FETCH: begin
                if (handshake) begin
                    // If a redirect lands in the same cycle, the old-PC request is still in flight.
                    state_d = redirect ? S_DROP : S_WAIT;
                end
                if (redirect) begin
                    pc_d         = redirect_addr;
                    inst_valid_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    pc_d         = redirect_addr;
                    inst_valid_d = 1'b0;
                    state_d      = imem_rsp_valid ? S_FETCH : S_DROP;
                end else if (imem_rsp_valid) begin
                    inst_d       = imem_rsp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    // A redirect wins over a consume in the same cycle.
                    pc_d         = redirect_addr;
                    inst_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end else if (inst_ready) begin
                    pc_d         = snpc_c;
                    inst_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end

            S_DROP: begin
                if (redirect) begin
                    pc_d         = redirect_addr;
                    inst_valid_d = 1'b0;
                end
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. Inputs are driven and outputs are sampled
// 1 ns after each rising clock edge.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic [31:0] pc;
    logic [31:0] snpc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .jump           (jump),
        .jump_target    (jump_target),
        .trap           (trap),
        .trap_vector    (trap_vector),
        .pc             (pc),
        .snpc           (snpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Afterwards, inputs may be driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set every input to its idle value.
    task automatic idle_inputs();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        jump           = 1'b0;
        jump_target    = 32'h0;
        trap           = 1'b0;
        trap_vector    = 32'h0;
    endtask

    // Pulse reset, then step through IDLE. The DUT ends in FETCH at pc=RESET_PC.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        n_tests++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h8000_0000); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", inst); end
        n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        rst = 1'b1;
        // The DUT is in IDLE, so no request yet.
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got=%b exp=0", imem_req_valid); end
        tick();
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", imem_req_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        logic [31:0] data;
        do_reset();
        inst_ready = 1'b1;
        exp_addr = 32'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            data = 32'h1000_0000 + 32'(k);
            n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin n_fail++; $display("FAIL seq_req[%0d] got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, exp_addr); end
            if (k == 0) begin
                n_tests++; if (snpc !== 32'h8000_0004) begin n_fail++; $display("FAIL seq_snpc got=%h exp=80000004", snpc); end
            end
            tick();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data;
            n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait_noreq[%0d] got=%b exp=0", k, imem_req_valid); end
            tick();
            imem_rsp_valid = 1'b0;
            n_tests++; if (inst_valid !== 1'b1 || inst !== data || inst_pc !== exp_addr) begin n_fail++; $display("FAIL seq_inst[%0d] got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst, inst_pc, data, exp_addr); end
            tick();
            exp_addr = exp_addr + 32'd4;
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_inst[%0d] got=%b/%h/%h exp=1/12345678/80000000", i, inst_valid, inst, inst_pc); end
            n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_noreq[%0d] got=%b exp=0", i, imem_req_valid); end
            n_tests++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_pc[%0d] got=%h exp=80000000", i, pc); end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_tests++; if (pc !== 32'h8000_0004 || inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%h/%b/%b exp=80000004/0/1", pc, inst_valid, imem_req_valid); end
    endtask

    task automatic test_jump_wait();
        do_reset();
        tick();
        jump = 1'b1;
        jump_target = 32'h8000_0101;
        tick();
        jump = 1'b0;
        n_tests++; if (pc !== 32'h8000_0100) begin n_fail++; $display("FAIL jw_pc got=%h exp=80000100", pc); end
        n_tests++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL jw_drop got=%b/%b exp=0/0", imem_req_valid, inst_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++; if (inst_valid !== 1'b0 || inst === 32'hDEAD_BEEF) begin n_fail++; $display("FAIL jw_discard got=%b/%h exp=0/not-deadbeef", inst_valid, inst); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL jw_next_req got=%b/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0113;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++; if (inst !== 32'h0000_0113 || inst_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL jw_refetch got=%h/%h exp=00000113/80000100", inst, inst_pc); end
    endtask

    task automatic test_trap_jump_hold();
        do_reset();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL tj_hold got=%b exp=1", inst_valid); end
        trap = 1'b1;
        trap_vector = 32'h8000_0207;
        jump = 1'b1;
        jump_target = 32'h8000_0300;
        inst_ready = 1'b1;
        tick();
        trap = 1'b0;
        jump = 1'b0;
        inst_ready = 1'b0;
        n_tests++; if (pc !== 32'h8000_0204) begin n_fail++; $display("FAIL tj_pc got=%h exp=80000204", pc); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL tj_inst_valid got=%b exp=0", inst_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0204) begin n_fail++; $display("FAIL tj_req got=%b/%h exp=1/80000204", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_handshake();
        do_reset();
        jump = 1'b1;
        jump_target = 32'h8000_1000;
        tick();
        jump = 1'b0;
        n_tests++; if (imem_req_valid !== 1'b0 || pc !== 32'h8000_1000) begin n_fail++; $display("FAIL rh_drop got=%b/%h exp=0/80001000", imem_req_valid, pc); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL rh_req2 got=%b/%b/%h exp=0/1/80001000", inst_valid, imem_req_valid, imem_req_addr); end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++; if (inst !== 32'h1111_1111 || inst_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL rh_inst got=%h/%h exp=11111111/80001000", inst, inst_pc); end
    endtask

    task automatic test_redirect_misc();
        do_reset();
        // A redirect in FETCH with no handshake keeps the request up at the new address.
        imem_req_ready = 1'b0;
        jump = 1'b1;
        jump_target = 32'h8000_2003;
        tick();
        jump = 1'b0;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_2002) begin n_fail++; $display("FAIL rm_fetch got=%b/%h exp=1/80002002", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        // A redirect in WAIT, in the same cycle as the response, goes straight to FETCH.
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_5555;
        jump = 1'b1;
        jump_target = 32'h8000_3000;
        tick();
        imem_rsp_valid = 1'b0;
        jump = 1'b0;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_3000 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rm_wait_rsp got=%b/%h/%b exp=1/80003000/0", imem_req_valid, imem_req_addr, inst_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hABCD_0001;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        inst_ready = 1'b0;
        tick();
        // The DUT is in WAIT with pc=80000004. Apply reset midway between edges.
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (pc !== 32'h8000_0000 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ar_pc_req got=%h/%b exp=80000000/0", pc, imem_req_valid); end
        n_tests++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL ar_inst got=%b/%h/%h exp=0/0/0", inst_valid, inst, inst_pc); end
        tick();
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ar_idle got=%b exp=0", imem_req_valid); end
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL ar_first_req got=%b/%h/%b exp=1/80000000/0", imem_req_valid, imem_req_addr, inst_valid); end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_jump_wait();
        test_trap_jump_hold();
        test_redirect_handshake();
        test_redirect_misc();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
